// File: rtl/reg_wr_arbiter_pkg.sv
// rtl/reg_wr_arbiter_pkg.sv - shared state encodings and defaults for the register-write arbiter
package reg_wr_arbiter_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;
    localparam int ID_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/reg_wr_arbiter_rr_pick.sv
// rtl/reg_wr_arbiter_rr_pick.sv - combinational round-robin picker, search starts just after ptr
module reg_wr_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          valid
);

    int c;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        c      = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!valid && req[c]) begin
                valid     = 1'b1;
                idx       = PW'(c);
                onehot[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// rtl/reg_wr_arbiter.sv - round-robin arbiter writing one of N requesters into a shared register
// Optional lock/burst feature enabled by defining ARB_LOCK_EN.
module reg_wr_arbiter
    import reg_wr_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    wdata,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]      lock,
`endif
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      ack,
    output logic [W-1:0]      q,
    output logic              busy,
    output logic [ID_W-1:0]   last_id
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, win, win_nxt, pick_idx;
    logic [N-1:0]  pick_oh, win_oh, gnt_nxt, ack_nxt;
    logic          pick_valid, req_w, lock_w, load_en;
    logic [W-1:0]  wsel;

    reg_wr_arbiter_rr_pick #(.N(N), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign win_oh = N'(1) << win;
    assign req_w  = req[win];
    assign busy   = (state != ST_IDLE);

`ifdef ARB_LOCK_EN
    assign lock_w = lock[win];
`else
    assign lock_w = 1'b0;
`endif

    always_comb begin
        wsel = '0;
        for (int i = 0; i < N; i++) begin
            if (win == PW'(i)) wsel = wdata[i*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_valid) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = req_w ? ST_ACK : ST_IDLE;
            ST_ACK:   state_nxt = (lock_w && req_w) ? ST_GRANT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A withdrawn winner simply drops back to IDLE without touching ptr.
    always_comb begin
        gnt_nxt = '0;
        ack_nxt = '0;
        win_nxt = win;
        load_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_nxt = pick_oh;
                    win_nxt = pick_idx;
                end
            end
            ST_GRANT: begin
                if (req_w) begin
                    ack_nxt = win_oh;
                    load_en = 1'b1;
                end
            end
            ST_ACK: begin
                if (lock_w && req_w) gnt_nxt = win_oh;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt     <= '0;
            ack     <= '0;
            win     <= '0;
            ptr     <= PW'(N-1);
            last_id <= '0;
        end else begin
            gnt <= gnt_nxt;
            ack <= ack_nxt;
            win <= win_nxt;
            if (load_en) begin
                ptr     <= win;
                last_id <= ID_W'(win);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       q <= '0;
        else if (load_en) q <= wsel;
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb/tb_reg_wr_arbiter.sv - randomized self-checking bench for reg_wr_arbiter (N=4, W=8)
module tb_reg_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt, ack;
    logic [W-1:0]   q;
    logic           busy;
    logic [2:0]     last_id;
`ifdef ARB_LOCK_EN
    logic [N-1:0]   lock;
`endif

    logic [W-1:0] d [N];
    int           checks = 0;
    int           passed = 0;
    int           m_ptr;
    int           m_last;
    logic [W-1:0] m_q;

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_wd
        assign wdata[i*W +: W] = d[i];
    end

    reg_wr_arbiter #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .wdata   (wdata),
`ifdef ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .ack     (ack),
        .q       (q),
        .busy    (busy),
        .last_id (last_id)
    );

    // Winner = first requester found walking forward from the last winner.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic serve_one(input bit withdraw);
        int w;
        w = pick(req, m_ptr);
        @(posedge clk); #1;
        checks++;
        if ({gnt, ack, busy} !== {oh(w), {N{1'b0}}, 1'b1})
            $display("FAIL grant: gnt=%b ack=%b busy=%b want gnt=%b ack=0 busy=1", gnt, ack, busy, oh(w));
        else passed++;
        if (withdraw) req[w] = 1'b0;
        @(posedge clk); #1;
        if (withdraw) begin
            checks++;
            if ({gnt, ack, busy, q} !== {{(2*N){1'b0}}, 1'b0, m_q})
                $display("FAIL withdraw: gnt=%b ack=%b busy=%b q=%h want 0/0/0 q=%h", gnt, ack, busy, q, m_q);
            else passed++;
        end else begin
            m_q = d[w]; m_last = w; m_ptr = w;
            checks++;
            if ({gnt, ack, busy, q, last_id} !== {{N{1'b0}}, oh(w), 1'b1, m_q, 3'(m_last)})
                $display("FAIL write: gnt=%b ack=%b busy=%b q=%h last_id=%0d want ack=%b q=%h last_id=%0d",
                         gnt, ack, busy, q, last_id, oh(w), m_q, m_last);
            else passed++;
            req[w] = 1'b0;
            @(posedge clk); #1;
            checks++;
            if ({gnt, ack, busy} !== '0)
                $display("FAIL ack_clear: gnt=%b ack=%b busy=%b want all 0", gnt, ack, busy);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0;
`ifdef ARB_LOCK_EN
        lock = '0;
`endif
        for (int i = 0; i < N; i++) d[i] = '0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({gnt, ack, busy, q, last_id} !== '0)
            $display("FAIL reset: gnt=%b ack=%b busy=%b q=%h last_id=%0d want all 0", gnt, ack, busy, q, last_id);
        else passed++;
        rst_n = 1'b1; m_ptr = N-1; m_q = '0; m_last = 0;
        req = 4'b0001;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0001) $display("FAIL pre_reset_gnt: gnt=%b want 0001", gnt);
        else passed++;
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({gnt, ack, busy, q, last_id} !== '0)
            $display("FAIL reset_mid_grant: gnt=%b ack=%b busy=%b q=%h last_id=%0d want all 0", gnt, ack, busy, q, last_id);
        else passed++;
        rst_n = 1'b1;
        req = 4'b1111; d[0] = 8'h11;
        serve_one(1'b0);
        checks++;
        if (last_id !== 3'd0) $display("FAIL reset_ptr: last_id=%0d want 0", last_id);
        else passed++;
        req = '0;
    endtask

    task automatic test_single();
        req = 4'b0100; d[2] = 8'hA5;
        serve_one(1'b0);
        checks++;
        if ({q, last_id} !== {8'hA5, 3'd2}) $display("FAIL single: q=%h last_id=%0d want a5/2", q, last_id);
        else passed++;
    endtask

    task automatic test_round_robin();
        req = 4'b1000; d[3] = 8'h3C;
        serve_one(1'b0);
        req = 4'b1111;
        for (int i = 0; i < N; i++) d[i] = W'($urandom);
        for (int i = 0; i < N; i++) begin
            serve_one(1'b0);
            checks++;
            if (last_id !== 3'(i)) $display("FAIL rr_order: last_id=%0d want %0d", last_id, i);
            else passed++;
        end
        req = 4'b1111;
        serve_one(1'b0);
        checks++;
        if (last_id !== 3'd0) $display("FAIL rr_wrap: last_id=%0d want 0", last_id);
        else passed++;
        req = '0;
    endtask

    task automatic test_withdraw();
        req = 4'b0100; d[2] = 8'h77;
        serve_one(1'b0);
        req = 4'b0010; d[1] = 8'hE1;
        serve_one(1'b1);
        req = 4'b0101; d[0] = 8'h0F;
        serve_one(1'b0);
        checks++;
        if (last_id !== 3'd0) $display("FAIL withdraw_ptr: last_id=%0d want 0", last_id);
        else passed++;
        serve_one(1'b0);
        req = '0;
    endtask

    task automatic test_contention();
        req = 4'b0010; d[1] = 8'h21;
        serve_one(1'b0);
        req = 4'b1010; d[1] = 8'h42; d[3] = 8'h93;
        serve_one(1'b0);
        checks++;
        if ({last_id, q} !== {3'd3, 8'h93}) $display("FAIL contention_first: last_id=%0d q=%h want 3/93", last_id, q);
        else passed++;
        serve_one(1'b0);
        checks++;
        if ({last_id, q} !== {3'd1, 8'h42}) $display("FAIL contention_second: last_id=%0d q=%h want 1/42", last_id, q);
        else passed++;
    endtask

    task automatic test_random();
        logic [N-1:0] add;
        for (int r = 0; r < 60; r++) begin
            add = N'($urandom);
            for (int i = 0; i < N; i++) if (add[i] && !req[i]) d[i] = W'($urandom);
            req = req | add;
            if (req == '0) begin
                @(posedge clk); #1;
                checks++;
                if ({gnt, ack, busy} !== '0) $display("FAIL idle: gnt=%b ack=%b busy=%b want all 0", gnt, ack, busy);
                else passed++;
            end else begin
                serve_one($urandom_range(0, 4) == 0);
            end
        end
        req = '0;
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        req = 4'b1000; d[3] = 8'hC3;
        serve_one(1'b0);
        d[0] = 8'h5A; d[1] = 8'hB4; lock = 4'b0001; req = 4'b0011;
        @(posedge clk); #1;
        checks++;
        if ({gnt, busy} !== {4'b0001, 1'b1}) $display("FAIL lock_grant: gnt=%b busy=%b want 0001/1", gnt, busy);
        else passed++;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            checks++;
            if ({gnt, ack, q} !== {4'b0000, 4'b0001, 8'h5A})
                $display("FAIL lock_write%0d: gnt=%b ack=%b q=%h want 0000/0001/5a", j, gnt, ack, q);
            else passed++;
            if (j == 2) begin
                lock = '0; req[0] = 1'b0;
            end else begin
                @(posedge clk); #1;
                checks++;
                if ({gnt, ack, busy} !== {4'b0001, 4'b0000, 1'b1})
                    $display("FAIL lock_regrant%0d: gnt=%b ack=%b busy=%b want 0001/0000/1", j, gnt, ack, busy);
                else passed++;
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({gnt, ack, busy} !== '0) $display("FAIL lock_release: gnt=%b ack=%b busy=%b want all 0", gnt, ack, busy);
        else passed++;
        m_ptr = 0; m_q = 8'h5A; m_last = 0;
        serve_one(1'b0);
        checks++;
        if (last_id !== 3'd1) $display("FAIL lock_next: last_id=%0d want 1", last_id);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_contention();
        test_random();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
